// File: rtl/mem_pkg.sv
// mem_pkg: width, state and owner codes shared by mem_ctrl.
// Default RAM address width for the byte-wide RAM.
package mem_pkg;

  localparam int MEM_AW = 17;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } mem_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } mem_own_t;

  typedef struct packed {
    logic        valid;
    mem_own_t    own;
    logic        write;
    logic [1:0]  last;
    logic [31:0] addr;
    logic        misal;
  } mem_req_t;

  // Index of the final byte: N-1 for N = 1/2/4.
  function automatic logic [1:0] mem_last_idx(
    input logic [1:0] w
  );
    logic [1:0] l;
    l = 2'd3;
    unique case (1'b1)
      (w == MEM_BYTE): l = 2'd0;
      (w == MEM_HALF): l = 2'd1;
      (w == MEM_WORD): l = 2'd3;
      default:         l = 2'd3;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: fixed-priority grant (data over fetch), byte count.
// MEM_CTRL_ALIGN_CHECK_EN adds the misalignment flag.
module mem_ctrl_arb
  import mem_pkg::*;
(
  input  logic        i_if_re,
  input  logic [31:0] i_if_addr,
  input  logic        i_d_re,
  input  logic        i_d_we,
  input  logic [1:0]  i_d_width,
  input  logic [31:0] i_d_addr,
  output mem_req_t    o_req
);

  always_comb begin
    o_req = '0;
    if (i_d_re || i_d_we) begin
      o_req.valid = 1'b1;
      o_req.own   = OWN_D;
      o_req.write = i_d_we;
      o_req.addr  = i_d_addr;
      o_req.last  = mem_last_idx(i_d_width);
    end else if (i_if_re) begin
      o_req.valid = 1'b1;
      o_req.own   = OWN_IF;
      o_req.write = 1'b0;
      o_req.addr  = i_if_addr;
      o_req.last  = 2'd3;
    end
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    o_req.misal =
      ((o_req.last == 2'd1) && o_req.addr[0]) ||
      ((o_req.last == 2'd3) &&
       (o_req.addr[1:0] != 2'd0));
`endif
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller for fetch and data ports.
// MEM_CTRL_ALIGN_CHECK_EN adds o_misalign and alignment rejection.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_if_re,
  input  logic [31:0]   i_if_addr,
  output logic [31:0]   o_if_data,
  output logic          o_if_done,
  input  logic          i_d_re,
  input  logic          i_d_we,
  input  logic [1:0]    i_d_width,
  input  logic [31:0]   i_d_addr,
  input  logic [31:0]   i_d_wdata,
  output logic [31:0]   o_d_rdata,
  output logic          o_d_done,
  output logic          o_mem_busy,
  output logic [AW-1:0] o_ram_addr,
  output logic          o_ram_we,
  output logic [7:0]    o_ram_wdata,
  input  logic [7:0]    i_ram_rdata
`ifdef MEM_CTRL_ALIGN_CHECK_EN
  ,
  output logic          o_misalign
`endif
);

  mem_req_t    w_req;
  mem_state_t  r_state;
  mem_state_t  w_nstate;
  mem_own_t    r_own;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [31:0] r_if_data;
  logic [31:0] r_d_rdata;
  logic [31:0] w_sum;
  logic [1:0]  r_cnt;
  logic [1:0]  r_last;
  logic [1:0]  r_cap_lane;
  logic        r_cap_en;
  logic        r_cap_last;
  logic        r_if_done;
  logic        r_d_done;
  logic        w_hold;
  logic        w_accept;
  logic        w_last;
  logic        w_unused;

  mem_ctrl_arb u_arb (
    .i_if_re   (i_if_re),
    .i_if_addr (i_if_addr),
    .i_d_re    (i_d_re),
    .i_d_we    (i_d_we),
    .i_d_width (i_d_width),
    .i_d_addr  (i_d_addr),
    .o_req     (w_req)
  );

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  logic r_mis_pend;
  logic r_misal;
  assign w_hold     = r_cap_en | r_mis_pend;
  assign o_misalign = r_misal;
`else
  assign w_hold = r_cap_en;
`endif

  // The last read byte lands one cycle after IDLE; hold off until then.
  assign w_accept = (r_state == IDLE) & ~w_hold & w_req.valid;
  assign w_last   = (r_cnt == r_last);
  assign w_sum    = r_base + {30'd0, r_cnt};
  assign w_unused = ^w_sum[31:AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept && !w_req.misal)
          w_nstate = w_req.write ? WR : RD;
      end
      RD, WR: begin
        if (w_last) w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
  end

  assign o_mem_busy  = (r_state != IDLE);
  assign o_ram_we    = (r_state == WR);
  assign o_ram_addr  = o_mem_busy ? w_sum[AW-1:0] : '0;
  assign o_ram_wdata = o_ram_we ?
    r_wdata[{r_cnt, 3'b000} +: 8] : 8'd0;
  assign o_if_data   = r_if_data;
  assign o_d_rdata   = r_d_rdata;
  assign o_if_done   = r_if_done;
  assign o_d_done    = r_d_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_own      <= OWN_IF;
      r_base     <= '0;
      r_wdata    <= '0;
      r_last     <= '0;
      r_cnt      <= '0;
      r_cap_en   <= 1'b0;
      r_cap_lane <= '0;
      r_cap_last <= 1'b0;
      r_if_data  <= '0;
      r_d_rdata  <= '0;
      r_if_done  <= 1'b0;
      r_d_done   <= 1'b0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
      r_mis_pend <= 1'b0;
      r_misal    <= 1'b0;
`endif
    end else begin
      r_if_done  <= 1'b0;
      r_d_done   <= 1'b0;
      r_cap_en   <= (r_state == RD);
      r_cap_lane <= r_cnt;
      r_cap_last <= (r_state == RD) && w_last;
      if (w_accept) begin
        r_own   <= w_req.own;
        r_base  <= w_req.addr;
        r_last  <= w_req.last;
        r_wdata <= i_d_wdata;
        r_cnt   <= '0;
        if (!w_req.misal && !w_req.write) begin
          if (w_req.own == OWN_IF) r_if_data <= '0;
          else                     r_d_rdata <= '0;
        end
      end else if (r_state != IDLE) begin
        r_cnt <= r_cnt + 2'd1;
      end
      if (r_cap_en) begin
        if (r_own == OWN_IF)
          r_if_data[{r_cap_lane, 3'b000} +: 8] <= i_ram_rdata;
        else
          r_d_rdata[{r_cap_lane, 3'b000} +: 8] <= i_ram_rdata;
        if (r_cap_last) begin
          if (r_own == OWN_IF) r_if_done <= 1'b1;
          else                 r_d_done  <= 1'b1;
        end
      end
      if ((r_state == WR) && w_last) r_d_done <= 1'b1;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
      r_misal    <= 1'b0;
      r_mis_pend <= w_accept && w_req.misal;
      if (r_mis_pend) begin
        r_misal <= 1'b1;
        if (r_own == OWN_IF) r_if_done <= 1'b1;
        else                 r_d_done  <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: vector table, corner sequences and random ops
// against a byte-array reference model of the RAM.
module tb_mem_ctrl;
  import mem_pkg::*;

  localparam int AW = MEM_AW;
  localparam logic [31:0] AMASK = (32'd1 << AW) - 32'd1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_re = 1'b0;
  logic [31:0]   if_addr = '0;
  logic [31:0]   if_data;
  logic          if_done;
  logic          d_re = 1'b0;
  logic          d_we = 1'b0;
  logic [1:0]    d_width = '0;
  logic [31:0]   d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic [31:0]   d_rdata;
  logic          d_done;
  logic          mem_busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
  logic          misalign;
`endif

  mem_ctrl #(.AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_if_re     (if_re),
    .i_if_addr   (if_addr),
    .o_if_data   (if_data),
    .o_if_done   (if_done),
    .i_d_re      (d_re),
    .i_d_we      (d_we),
    .i_d_width   (d_width),
    .i_d_addr    (d_addr),
    .i_d_wdata   (d_wdata),
    .o_d_rdata   (d_rdata),
    .o_d_done    (d_done),
    .o_mem_busy  (mem_busy),
    .o_ram_addr  (ram_addr),
    .o_ram_we    (ram_we),
    .o_ram_wdata (ram_wdata),
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    .o_misalign  (misalign),
`endif
    .i_ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_if = '0;
  logic [31:0] exp_d = '0;

  typedef struct {
    bit          own_if;
    bit          wr;
    logic [1:0]  w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input bit own_if,
                                input logic [1:0] w);
    if (own_if || w >= 2'd2) return 4;
    return (w == 2'd1) ? 2 : 1;
  endfunction

  function automatic bit is_mis(input int n,
                                input logic [31:0] a);
    bit m;
    m = 1'b0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    m = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'd0);
`endif
    return m;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a,
                                           input int n);
    logic [31:0] v;
    logic [31:0] ad;
    v = '0;
    for (int k = 0; k < n; k++) begin
      ad = (a + k) & AMASK;
      v[8*k +: 8] = ref_mem[ad[AW-1:0]];
    end
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] a,
                           input int n,
                           input logic [31:0] wd);
    logic [31:0] ad;
    for (int k = 0; k < n; k++) begin
      ad = (a + k) & AMASK;
      ref_mem[ad[AW-1:0]] = wd[8*k +: 8];
    end
  endtask

  // Issues one request, waits for its done; checks busy/we/other-done.
  task automatic do_op(input bit own_if, input bit wr,
                       input logic [1:0] w,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input string nm,
                       output logic [31:0] rd,
                       output int lat);
    int  n;
    int  busy;
    int  wes;
    bit  mis;
    bit  seen;
    bit  other;
    n = nbytes(own_if, w);
    mis = is_mis(n, a);
    if (own_if) begin
      if_re = 1'b1;
      if_addr = a;
    end else begin
      d_re = !wr;
      d_we = wr;
      d_width = w;
      d_addr = a;
      d_wdata = wd;
    end
    @(posedge clk);
    #1;
    if_re = 1'b0;
    d_re = 1'b0;
    d_we = 1'b0;
    busy = 0;
    wes = 0;
    seen = 1'b0;
    other = 1'b0;
    lat = 0;
    rd = '0;
    for (int c = 0; c < 12 && !seen; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (own_if ? if_done : d_done) begin
        seen = 1'b1;
        lat = c;
        rd = own_if ? if_data : d_rdata;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        chk({nm, "_misalign"}, {31'd0, misalign},
            {31'd0, mis});
`endif
      end
      if (own_if ? d_done : if_done) other = 1'b1;
      busy += int'(mem_busy);
      wes += int'(ram_we);
    end
    chk({nm, "_busy"}, 32'(busy), mis ? 32'd0 : 32'(n));
    chk({nm, "_we"}, 32'(wes),
        (wr && !mis) ? 32'(n) : 32'd0);
    chk({nm, "_otherdone"}, {31'd0, other}, 32'd0);
  endtask

  logic [31:0] rd;
  logic [31:0] ex;
  int          lat;
  int          n;
  bit          mis;
  int          c;
  bit          seen;
  bit          own_if;
  bit          wr;
  logic [1:0]  w;
  logic [31:0] a;
  logic [31:0] wd;
  int          diffs;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] <= 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem[16] <= 8'h13;
    mem[17] <= 8'h05;
    mem[18] <= 8'h50;
    mem[19] <= 8'h00;
    ref_mem[16] = 8'h13;
    ref_mem[17] = 8'h05;
    ref_mem[18] = 8'h50;
    ref_mem[19] = 8'h00;

    tbl[0]  = '{1'b1, 1'b0, 2'd2, 32'h10, 32'h0,
                32'h00500513, 5};
    tbl[1]  = '{1'b0, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF,
                32'h0, 4};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 32'h101, 32'h0,
                32'h000000BE, 2};
    tbl[3]  = '{1'b0, 1'b0, 2'd1, 32'h102, 32'h0,
                32'h0000DEAD, 3};
    tbl[4]  = '{1'b0, 1'b0, 2'd2, 32'h100, 32'h0,
                32'hDEADBEEF, 5};
    tbl[5]  = '{1'b0, 1'b0, 2'd3, 32'h100, 32'h0,
                32'hDEADBEEF, 5};
    tbl[6]  = '{1'b0, 1'b1, 2'd1, 32'h300, 32'h1234CAFE,
                32'h0, 2};
    tbl[7]  = '{1'b0, 1'b0, 2'd2, 32'h300, 32'h0,
                32'h0000CAFE, 5};
    tbl[8]  = '{1'b0, 1'b1, 2'd0, 32'h303, 32'h777777A5,
                32'h0, 1};
    tbl[9]  = '{1'b0, 1'b0, 2'd2, 32'h300, 32'h0,
                32'hA500CAFE, 5};
    tbl[10] = '{1'b1, 1'b0, 2'd2, 32'h00020010, 32'h0,
                32'h00500513, 5};
    tbl[11] = '{1'b0, 1'b0, 2'd0, 32'hFFFE0303, 32'h0,
                32'h000000A5, 2};
    tbl[12] = '{1'b1, 1'b0, 2'd2, 32'h100, 32'h0,
                32'hDEADBEEF, 5};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_flags", {27'd0, if_done, d_done, mem_busy,
                      ram_we, 1'b0}, 32'h0);
    chk("rst_ram", {7'd0, ram_addr, ram_wdata}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      do_op(tbl[i].own_if, tbl[i].wr, tbl[i].w, tbl[i].a,
            tbl[i].wd, $sformatf("vec%0d", i), rd, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat),
          32'(tbl[i].lat));
      n = nbytes(tbl[i].own_if, tbl[i].w);
      if (tbl[i].wr) begin
        ref_write(tbl[i].a, n, tbl[i].wd);
      end else begin
        chk($sformatf("vec%0d_rd", i), rd, tbl[i].rd);
        if (tbl[i].own_if) exp_if = tbl[i].rd;
        else               exp_d = tbl[i].rd;
      end
    end

    // Contention: data byte read wins, fetch follows on the done edge.
    if_re = 1'b1;
    if_addr = 32'h10;
    d_re = 1'b1;
    d_width = MEM_BYTE;
    d_addr = 32'h101;
    @(posedge clk);
    #1;
    d_re = 1'b0;
    seen = 1'b0;
    lat = 0;
    for (c = 1; c < 12 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (d_done) begin
        seen = 1'b1;
        lat = c;
      end
      if (if_done) chk("cont_early_ifdone", 32'd1, 32'd0);
    end
    chk("cont_d_lat", 32'(lat), 32'd2);
    chk("cont_d_rdata", d_rdata, 32'h000000BE);
    chk("cont_done_busy", {31'd0, mem_busy}, 32'd0);
    exp_d = 32'h000000BE;
    @(posedge clk);
    #1;
    chk("cont_if_accept", {31'd0, mem_busy}, 32'd1);
    if_re = 1'b0;
    seen = 1'b0;
    lat = 0;
    for (c = 1; c < 12 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (if_done) begin
        seen = 1'b1;
        lat = c;
      end
    end
    chk("cont_if_lat", 32'(lat), 32'd5);
    chk("cont_if_data", if_data, 32'h00500513);
    exp_if = 32'h00500513;

    // Word read at 0x102: rejected with the check, byte-wise without.
    do_op(1'b0, 1'b0, MEM_WORD, 32'h102, 32'h0, "unal",
          rd, lat);
    mis = is_mis(4, 32'h102);
    ex = mis ? exp_d : ref_read(32'h102, 4);
    chk("unal_lat", 32'(lat), mis ? 32'd1 : 32'd5);
    chk("unal_rd", rd, ex);
    exp_d = ex;

    // Reset after two bytes of a word write.
    d_we = 1'b1;
    d_width = MEM_WORD;
    d_addr = 32'h200;
    d_wdata = 32'h11223344;
    @(posedge clk);
    #1;
    d_we = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_we", {31'd0, ram_we}, 32'd0);
    chk("rstmid_busy", {31'd0, mem_busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (d_done) seen = 1'b1;
    end
    chk("rstmid_nodone", {31'd0, seen}, 32'd0);
    chk("rstmid_ram",
        {mem[32'h200], mem[32'h201], mem[32'h202],
         mem[32'h203]}, 32'h44330000);
    chk("rstmid_d_rdata", d_rdata, 32'h0);
    ref_mem[32'h200] = 8'h44;
    ref_mem[32'h201] = 8'h33;
    exp_d = '0;
    exp_if = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(1'b1, 1'b0, MEM_WORD, 32'h10, 32'h0, "postrst",
          rd, lat);
    chk("postrst_lat", 32'(lat), 32'd5);
    chk("postrst_rd", rd, 32'h00500513);
    exp_if = rd;

    for (int i = 0; i < 200; i++) begin
      own_if = ($urandom_range(0, 3) == 0);
      wr = !own_if && ($urandom_range(0, 1) == 1);
      w = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 3)
        a = 32'h1FFF8 + $urandom_range(0, 7);
      else
        a = 32'h400 + $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1)
        a = a | ($urandom & ~AMASK);
      wd = $urandom;
      n = nbytes(own_if, w);
      mis = is_mis(n, a);
      do_op(own_if, wr, w, a, wd, "rnd", rd, lat);
      chk("rnd_lat", 32'(lat),
          mis ? 32'd1 : (wr ? 32'(n) : 32'(n + 1)));
      if (!wr) begin
        ex = mis ? (own_if ? exp_if : exp_d) :
                   ref_read(a, n);
        chk("rnd_rd", rd, ex);
        if (own_if) exp_if = ex;
        else        exp_d = ex;
      end else if (!mis) begin
        ref_write(a, n, wd);
      end
    end

    diffs = 0;
    for (int i = 0; i < 16; i++) begin
      if (mem[i] !== ref_mem[i]) diffs++;
      if (mem[32'h1FFF0 + i] !== ref_mem[32'h1FFF0 + i])
        diffs++;
    end
    for (int i = 32'h400; i < 32'h510; i++)
      if (mem[i] !== ref_mem[i]) diffs++;
    chk("ram_sweep_diffs", 32'(diffs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
